// File: rtl/instr_fetch.sv
// Instruction fetch: keeps one imem request in flight and fills a 2-entry {pc, instr} buffer for decode.
// if_valid rises 1 cycle after imem_rsp_valid; a redirect flushes the buffer and drops any in-flight response.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, req_pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_after;
  logic        accept, push, pop;

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign if_valid       = (count != 2'd0);
  assign pop            = if_valid & if_ready & ~redirect_valid;
  // Only a response to our own outstanding request is captured; stale ones land in IDLE/REQ/DROP.
  assign push           = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
  assign if_pc          = buf_pc[rd_ptr];
  assign if_instr       = buf_instr[rd_ptr];

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    count_after = count + {1'b0, push} - {1'b0, pop};
    if (accept) pc_nxt = pc + 32'd4;
    case (state)
      IDLE:    if (count < 2'd2) state_nxt = REQ;
      REQ:     if (accept) state_nxt = WAIT;
      WAIT:    if (imem_rsp_valid) state_nxt = (count_after < 2'd2) ? REQ : IDLE;
      DROP:    if (imem_rsp_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      pc_nxt = {redirect_pc[31:2], 2'b00};
      // A request the memory took this cycle still owes a response, which must be discarded.
      case (state)
        IDLE, REQ: state_nxt = accept ? DROP : REQ;
        default:   state_nxt = imem_rsp_valid ? REQ : DROP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (accept) req_pc <= pc;
      if (redirect_valid) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]    <= req_pc;
          buf_instr[wr_ptr] <= imem_rdata;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count_after;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory/decode/redirect traffic against a program-order reference model.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'hFFFFFFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, if_valid, if_ready;
  logic [31:0] redirect_pc, if_instr, if_pc;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: next address the program stream must request / deliver to decode.
  logic [31:0] exp_req, exp_pc;
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  bit          stall_d, redir_d;
  logic [31:0] stall_addr;
  int          pops, accepts;
  logic [31:0] acc_q[$];

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a ^ 32'hDEADBEEF) + {a[7:0], 24'h0};
  endfunction

  // One clock: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input bit rdy, input bit ifr, input bit redir, input logic [31:0] tgt, input int dly);
    @(negedge clk);
    if (redir_d) begin
      total++;
      if (if_valid !== 1'b0) begin bad++; $display("FAIL redirect_flush: if_valid=%b want 0", if_valid); end
    end
    if (stall_d) begin
      total++;
      if (imem_req_valid !== 1'b1 || imem_addr !== stall_addr) begin
        bad++; $display("FAIL req_stable: valid=%b addr=%h want 1 %h", imem_req_valid, imem_addr, stall_addr);
      end
    end
    imem_req_ready = rdy;
    if_ready       = ifr;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (mem_busy && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = imem_word(mem_addr);
      mem_busy       = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = $urandom;
      if (mem_busy) mem_cnt--;
    end
    if (if_valid === 1'b1 && ifr && !redir) begin
      total++;
      if (if_pc !== exp_pc || if_instr !== imem_word(exp_pc)) begin
        bad++; $display("FAIL decode_entry: pc=%h instr=%h want %h %h", if_pc, if_instr, exp_pc, imem_word(exp_pc));
      end
      exp_pc += 32'd4;
      pops++;
    end
    if (imem_req_valid === 1'b1 && rdy) begin
      total++;
      if (imem_addr !== exp_req || mem_busy) begin
        bad++; $display("FAIL fetch_addr: addr=%h busy=%b want %h 0", imem_addr, mem_busy, exp_req);
      end
      exp_req += 32'd4;
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = dly;
      accepts++;
      acc_q.push_back(imem_addr);
    end
    stall_d    = (imem_req_valid === 1'b1) && !rdy && !redir;
    stall_addr = imem_addr;
    redir_d    = redir;
    if (redir) begin
      exp_req = {tgt[31:2], 2'b00};
      exp_pc  = exp_req;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; stall_d = 1'b0; redir_d = 1'b0; pops = 0; accepts = 0;
    repeat (3) @(negedge clk);
    total += 5;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: %b want 0", imem_req_valid); end
    if (if_valid !== 1'b0)       begin bad++; $display("FAIL rst_if_valid: %b want 0", if_valid); end
    if (imem_addr !== RST_PC)    begin bad++; $display("FAIL rst_addr: %h want %h", imem_addr, RST_PC); end
    if (if_pc !== 32'h0)         begin bad++; $display("FAIL rst_if_pc: %h want 0", if_pc); end
    if (if_instr !== 32'h0)      begin bad++; $display("FAIL rst_if_instr: %h want 0", if_instr); end
    rst = 1'b0;
    exp_req = RST_PC; exp_pc = RST_PC; acc_q.delete();
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      bad++; $display("FAIL first_req: valid=%b addr=%h want 1 %h", imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    total += 2;
    if (acc_q.size() < 3 || acc_q[0] !== 32'hFFFFFFFC || acc_q[1] !== 32'h0 || acc_q[2] !== 32'h4) begin
      bad++; $display("FAIL stream_order: n=%0d first=%h want fffffffc,0,4", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 32'hx);
    end
    if (pops < 3) begin bad++; $display("FAIL stream_pops: %0d want >=3", pops); end
  endtask

  task automatic test_backpressure;
    int a0, p0;
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 0);
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
        bad++; $display("FAIL full_hold: req_valid=%b if_valid=%b want 0 1", imem_req_valid, if_valid);
      end
    end
    a0 = accepts;
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 0);
    total++;
    if (accepts - a0 != 1) begin bad++; $display("FAIL refill_one: accepts=%0d want 1", accepts - a0); end
    p0 = pops;
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 0);
    total += 2;
    if (pops - p0 != 2) begin bad++; $display("FAIL buffer_depth: pops=%0d want 2", pops - p0); end
    if (if_valid !== 1'b0) begin bad++; $display("FAIL drained: if_valid=%b want 0", if_valid); end
  endtask

  task automatic test_stall;
    logic [31:0] a;
    int n;
    a = imem_addr;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 0);
      total++;
      if (imem_req_valid !== 1'b1 || imem_addr !== a) begin
        bad++; $display("FAIL stall_hold: valid=%b addr=%h want 1 %h", imem_req_valid, imem_addr, a);
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 0);
    n = 0;
    do begin step(1'b0, 1'b1, 1'b0, 32'h0, 0); n++; end while (imem_req_valid !== 1'b1 && n < 20);
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== a + 32'd4) begin
      bad++; $display("FAIL stall_advance: valid=%b addr=%h want 1 %h", imem_req_valid, imem_addr, a + 32'd4);
    end
  endtask

  task automatic test_redirect;
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin step(1'b0, 1'b1, 1'b0, 32'h0, 0); n++; end
    step(1'b1, 1'b1, 1'b0, 32'h0, 3);
    step(1'b0, 1'b1, 1'b1, 32'h00000103, 0);
    acc_q.delete();
    n = 0;
    do begin step(1'b1, 1'b0, 1'b0, 32'h0, 0); n++; end while (if_valid !== 1'b1 && n < 30);
    total += 2;
    if (acc_q.size() < 1 || acc_q[0] !== 32'h100) begin
      bad++; $display("FAIL redirect_addr: n=%0d addr=%h want 100", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 32'hx);
    end
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== imem_word(32'h100)) begin
      bad++; $display("FAIL redirect_first: v=%b pc=%h instr=%h want 1 100 %h", if_valid, if_pc, if_instr, imem_word(32'h100));
    end
  endtask

  task automatic test_random;
    int p0;
    p0 = pops;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
           $urandom, int'($urandom_range(0, 3)));
    total++;
    if (pops - p0 < 100) begin bad++; $display("FAIL random_progress: pops=%0d want >=100", pops - p0); end
  endtask

  task automatic test_reset_mid;
    int n, p0;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin step(1'b0, 1'b1, 1'b0, 32'h0, 0); n++; end
    step(1'b1, 1'b0, 1'b0, 32'h0, 3);
    step(1'b0, 1'b0, 1'b0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || imem_addr !== RST_PC) begin
      bad++; $display("FAIL async_rst: req=%b ifv=%b addr=%h want 0 0 %h", imem_req_valid, if_valid, imem_addr, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
    exp_req = RST_PC; exp_pc = RST_PC; stall_d = 1'b0; redir_d = 1'b0; mem_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0, 0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 0);
    total++;
    if (if_valid !== 1'b0) begin bad++; $display("FAIL stale_rsp: if_valid=%b want 0", if_valid); end
    p0 = pops; n = 0;
    while (pops - p0 < 3 && n < 40) begin step(1'b1, 1'b1, 1'b0, 32'h0, 1); n++; end
    total++;
    if (pops - p0 < 3) begin bad++; $display("FAIL post_rst_fetch: pops=%0d want 3", pops - p0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request when high with imem_req_valid.
REQ-006 imem_addr  output  32  fetch address; equals the internal PC while imem_req_valid is high.
REQ-007 imem_rsp_valid  input  1  instruction word returned; one per accepted request, in order, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  instruction word, qualified by imem_rsp_valid.
REQ-009 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-010 redirect_pc  input  32  redirect target, qualified by redirect_valid.
REQ-011 if_valid  output  1  fetched instruction available to decode.
REQ-012 if_ready  input  1  decode consumes the head entry when high with if_valid.
REQ-013 if_instr  output  32  head instruction word.
REQ-014 if_pc  output  32  address the head instruction was fetched from.

Function
REQ-015 The block SHALL hold a 32-bit PC register and a 2-entry in-order {pc, instr} buffer feeding if_*.
REQ-016 The block SHALL keep at most one request outstanding (accepted, response not yet received).
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP.
REQ-018 IDLE -> REQ when buffer count + 0 < 2 and no redirect; REQ drives imem_req_valid=1, imem_addr=PC.
REQ-019 REQ: imem_req_valid and imem_addr SHALL stay stable until imem_req_ready; on acceptance PC <= PC + 4 (modulo 2^32, 32'hFFFFFFFC wraps to 0) and state -> WAIT.
REQ-020 WAIT: on imem_rsp_valid, {fetched pc, imem_rdata} SHALL be written to the buffer tail; state -> REQ if buffer has a free slot after this cycle's pop/push, else IDLE.
REQ-021 A request SHALL only be issued when buffer count (after same-cycle pop) is below 2, so a response always has a free slot.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; pop from empty and push to full SHALL never occur.
REQ-023 if_valid SHALL equal (count != 0); if_instr/if_pc SHALL be the head entry, combinational from buffer state, no bypass of imem_rdata (fetch-to-if_valid latency = 1 cycle after imem_rsp_valid).
REQ-024 redirect_valid SHALL, in the same edge: flush the buffer (count <= 0), load PC <= {redirect_pc[31:2], 2'b00}, and override any same-cycle pop/push.
REQ-025 Redirect in IDLE or REQ (not accepted this cycle) SHALL go to REQ with the new PC; an unaccepted request is withdrawn.
REQ-026 Redirect in WAIT, or in REQ with imem_req_ready=1 that cycle, SHALL go to DROP; redirect coincident with imem_rsp_valid in WAIT SHALL discard that response and go to REQ.
REQ-027 DROP: the next imem_rsp_valid SHALL be discarded (no push), state -> REQ; a further redirect in DROP only updates PC.
REQ-028 if_valid SHALL be 0 in the cycle after a redirect and until a post-redirect response arrives.

Reset
REQ-029 On rst high, asynchronously: PC=RESET_PC, state=IDLE, count=0, imem_req_valid=0, if_valid=0, imem_addr=RESET_PC, if_pc=0, if_instr=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding request; responses arriving after rst release with no request issued SHALL be ignored.
REQ-031 First request SHALL be issued in the cycle after rst deasserts, at RESET_PC.

Verification
REQ-032 Reset release, memory ready=1, rsp 1 cycle later, if_ready=1 -> addresses 0x0,0x4,0x8,... in order; if_pc/if_instr match each response.
REQ-033 if_ready=0 held -> exactly 2 entries buffered, imem_req_valid stays 0 afterwards; if_ready=1 for one cycle -> one pop, one new request at next PC.
REQ-034 imem_req_ready=0 for 3 cycles -> imem_addr/imem_req_valid stable all 3 cycles, PC advances only on acceptance.
REQ-035 Redirect to 0x00000103 while WAIT -> pending response dropped, next request at 0x00000100, buffer empty, if_valid=0 until new response.
REQ-036 RESET_PC=32'hFFFFFFFC -> first fetch 0xFFFFFFFC, second fetch 0x00000000.
REQ-037 rst asserted while WAIT, then released -> stale imem_rsp_valid ignored, fresh fetch at RESET_PC, no buffer entry from stale response.
